// File: rtl/add_arbiter.sv
// Round-robin controller sharing one single-precision add/subtract datapath
// between two requesters: grant, issue, wait a fixed settle time, return result.
module add_arbiter #(
    parameter int ADD_LAT = 1,
    parameter int WAIT_W  = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req0,
    input  logic        sub0,
    input  logic [31:0] opa0,
    input  logic [31:0] opb0,
    input  logic        req1,
    input  logic        sub1,
    input  logic [31:0] opa1,
    input  logic [31:0] opb1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] res0,
    output logic [31:0] res1,
    output logic        ovf0,
    output logic        ovf1,
    output logic [31:0] add_op1,
    output logic [31:0] add_op2,
    output logic        add_serv,
    input  logic [31:0] add_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last;
    logic              r_win;
    logic [WAIT_W-1:0] r_cnt;

    logic              w_any_req;
    logic              w_grant;
    logic              w_cnt_last;
    logic              w_capture;
    logic              w_ovf;
    logic [31:0]       w_opa_sel;
    logic [31:0]       w_opb_sel;
    logic              w_sub_sel;

    assign w_any_req  = req0 | req1;
    // On a tie the requester that was not served last wins; otherwise whoever asks.
    assign w_grant    = (req0 & req1) ? ~r_last : req1;
    assign w_cnt_last = (r_cnt == WAIT_W'(1));
    assign w_capture  = (r_state == S_WAIT) && w_cnt_last;

    assign w_opa_sel  = w_grant ? opa1 : opa0;
    assign w_opb_sel  = w_grant ? opb1 : opb0;
    assign w_sub_sel  = w_grant ? sub1 : sub0;

    // An all-ones exponent from finite operands means the sum overflowed to infinity.
    assign w_ovf = (add_result[30:23] == 8'hFF)
                && (add_op1[30:23] != 8'hFF)
                && (add_op2[30:23] != 8'hFF);

    always_comb begin
        // NOTE: default assigned first so every path drives w_next_state; no latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (w_cnt_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_last  <= 1'b1;
            r_win   <= 1'b0;
            r_cnt   <= '0;
            add_op1 <= '0;
            add_op2 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_win   <= w_grant;
                        r_last  <= w_grant;
                        add_op1 <= w_opa_sel;
                        add_op2 <= {w_opb_sel[31] ^ w_sub_sel, w_opb_sel[30:0]};
                    end
                end
                S_ISSUE: r_cnt <= WAIT_W'(ADD_LAT);
                S_WAIT:  r_cnt <= r_cnt - WAIT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            res0 <= '0;
            res1 <= '0;
            ovf0 <= 1'b0;
            ovf1 <= 1'b0;
        end else if (w_capture) begin
            if (r_win) begin
                res1 <= add_result;
                ovf1 <= w_ovf;
            end else begin
                res0 <= add_result;
                ovf0 <= w_ovf;
            end
        end
    end

    // Handshake strobes decode the state, so they cannot overlap across channels.
    assign ack0     = (r_state == S_ISSUE) && !r_win;
    assign ack1     = (r_state == S_ISSUE) &&  r_win;
    assign done0    = (r_state == S_DONE)  && !r_win;
    assign done1    = (r_state == S_DONE)  &&  r_win;
    assign add_serv = (r_state == S_ISSUE);
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: scoreboard of expected results, a
// table-driven datapath model, and one task per scenario.
module tb_add_arbiter;

    typedef struct {
        int          chan;
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          ack_cyc;
        int          ack_chan;
        int          done_cyc;
        int          done_chan;
        logic        serv_at_ack;
        logic [31:0] op2_at_ack;
        logic [31:0] res;
        logic        ovf;
        int          excl_bad;
    } obs_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    // DUT A: ADD_LAT = 1
    logic        req0 = 0, sub0 = 0, req1 = 0, sub1 = 0;
    logic [31:0] opa0 = '0, opb0 = '0, opa1 = '0, opb1 = '0;
    logic        ack0, ack1, done0, done1, ovf0, ovf1, add_serv, busy;
    logic [31:0] res0, res1, add_op1, add_op2, add_result;

    // DUT B: ADD_LAT = 4
    logic        req0_b = 0, sub0_b = 0, req1_b = 0, sub1_b = 0;
    logic [31:0] opa0_b = '0, opb0_b = '0, opa1_b = '0, opb1_b = '0;
    logic        ack0_b, ack1_b, done0_b, done1_b, ovf0_b, ovf1_b, add_serv_b, busy_b;
    logic [31:0] res0_b, res1_b, add_op1_b, add_op2_b, add_result_b;

    // Datapath stand-in: known sums for the vectors used here.
    function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b);
        if      (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        else if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
        else if (a == 32'h7F000000 && b == 32'h7F000000) return 32'h7F800000;
        else if (a == 32'h7F800000 && b == 32'h3F800000) return 32'h7F800000;
        else return a ^ b;
    endfunction

    assign add_result   = dp_model(add_op1, add_op2);
    assign add_result_b = dp_model(add_op1_b, add_op2_b);

    add_arbiter #(.ADD_LAT(1), .WAIT_W(4)) dut (
        .clk(clk), .n_rst(n_rst),
        .req0(req0), .sub0(sub0), .opa0(opa0), .opb0(opb0),
        .req1(req1), .sub1(sub1), .opa1(opa1), .opb1(opb1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .res0(res0), .res1(res1), .ovf0(ovf0), .ovf1(ovf1),
        .add_op1(add_op1), .add_op2(add_op2), .add_serv(add_serv),
        .add_result(add_result), .busy(busy)
    );

    add_arbiter #(.ADD_LAT(4), .WAIT_W(4)) dut_b (
        .clk(clk), .n_rst(n_rst),
        .req0(req0_b), .sub0(sub0_b), .opa0(opa0_b), .opb0(opb0_b),
        .req1(req1_b), .sub1(sub1_b), .opa1(opa1_b), .opb1(opb1_b),
        .ack0(ack0_b), .ack1(ack1_b), .done0(done0_b), .done1(done1_b),
        .res0(res0_b), .res1(res1_b), .ovf0(ovf0_b), .ovf1(ovf1_b),
        .add_op1(add_op1_b), .add_op2(add_op2_b), .add_serv(add_serv_b),
        .add_result(add_result_b), .busy(busy_b)
    );

    // Drives one operation on DUT A from IDLE and records what happened.
    // Called at a negedge with the controller idle; returns at a negedge in IDLE.
    task automatic run_op(input int chan, input logic sub, input logic [31:0] a,
                          input logic [31:0] b, output obs_t o);
        o.ack_cyc = -1; o.ack_chan = -1; o.done_cyc = -1; o.done_chan = -1;
        o.serv_at_ack = 1'b0; o.op2_at_ack = '0; o.res = '0; o.ovf = 1'b0;
        o.excl_bad = 0;
        if (chan == 0) begin
            req0 = 1; sub0 = sub; opa0 = a; opb0 = b;
        end else begin
            req1 = 1; sub1 = sub; opa1 = a; opb1 = b;
        end
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if ((ack0 & ack1) | (done0 & done1) | ((ack0 | ack1) & (done0 | done1)))
                o.excl_bad++;
            if ((ack0 | ack1) && o.ack_cyc < 0) begin
                o.ack_cyc     = n;
                o.ack_chan    = ack1 ? 1 : 0;
                o.serv_at_ack = add_serv;
                o.op2_at_ack  = add_op2;
                req0 = 0; req1 = 0;
            end
            if (done0 | done1) begin
                o.done_cyc  = n;
                o.done_chan = done1 ? 1 : 0;
                o.res       = done1 ? res1 : res0;
                o.ovf       = done1 ? ovf1 : ovf0;
                @(negedge clk);
                break;
            end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_reset();
        n_rst = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack0, ack1, done0, done1, ovf0, ovf1, add_serv, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 00000000",
                     {ack0, ack1, done0, done1, ovf0, ovf1, add_serv, busy});
        end
        checks++;
        if ({res0, res1, add_op1, add_op2} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {res0, res1, add_op1, add_op2});
        end
        n_rst = 1;
        @(negedge clk);
    endtask

    task automatic test_add0();
        obs_t o;
        exp_t e;
        exp_q.push_back('{chan: 0, res: 32'h40400000, ovf: 1'b0});
        run_op(0, 1'b0, 32'h3F800000, 32'h40000000, o);
        checks++;
        if (o.ack_cyc !== 1 || o.ack_chan !== 0) begin
            errors++;
            $display("FAIL add0_ack: got cyc %0d chan %0d want cyc 1 chan 0", o.ack_cyc, o.ack_chan);
        end
        checks++;
        if (o.serv_at_ack !== 1'b1) begin
            errors++;
            $display("FAIL add0_serv: got %b want 1", o.serv_at_ack);
        end
        checks++;
        if (o.done_cyc !== 3 || o.done_chan !== 0) begin
            errors++;
            $display("FAIL add0_done: got cyc %0d chan %0d want cyc 3 chan 0", o.done_cyc, o.done_chan);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL add0_sb: got empty scoreboard want one entry");
        end else begin
            e = exp_q.pop_front();
            if (o.res !== e.res || o.ovf !== e.ovf) begin
                errors++;
                $display("FAIL add0_res: got %h ovf %b want %h ovf %b", o.res, o.ovf, e.res, e.ovf);
            end
        end
        checks++;
        if (o.excl_bad !== 0) begin
            errors++;
            $display("FAIL add0_excl: got %0d overlaps want 0", o.excl_bad);
        end
    endtask

    task automatic test_sub1();
        obs_t o;
        exp_t e;
        exp_q.push_back('{chan: 1, res: 32'h40000000, ovf: 1'b0});
        run_op(1, 1'b1, 32'h40400000, 32'h3F800000, o);
        checks++;
        if (o.op2_at_ack !== 32'hBF800000) begin
            errors++;
            $display("FAIL sub1_op2: got %h want BF800000", o.op2_at_ack);
        end
        checks++;
        if (o.ack_chan !== 1 || o.done_chan !== 1 || o.done_cyc !== 3) begin
            errors++;
            $display("FAIL sub1_chan: got ack %0d done %0d@%0d want ack 1 done 1@3",
                     o.ack_chan, o.done_chan, o.done_cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sub1_sb: got empty scoreboard want one entry");
        end else begin
            e = exp_q.pop_front();
            if (o.res !== e.res || o.ovf !== e.ovf) begin
                errors++;
                $display("FAIL sub1_res: got %h ovf %b want %h ovf %b", o.res, o.ovf, e.res, e.ovf);
            end
        end
        checks++;
        if (res0 !== 32'h40400000 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL sub1_res0_kept: got %h ovf %b want 40400000 ovf 0", res0, ovf0);
        end
    endtask

    task automatic test_overflow();
        obs_t o;
        exp_t e;
        exp_q.push_back('{chan: 0, res: 32'h7F800000, ovf: 1'b1});
        exp_q.push_back('{chan: 0, res: 32'h7F800000, ovf: 1'b0});
        run_op(0, 1'b0, 32'h7F000000, 32'h7F000000, o);
        checks++;
        e = exp_q.pop_front();
        if (o.res !== e.res || o.ovf !== e.ovf || o.done_chan !== e.chan) begin
            errors++;
            $display("FAIL ovf_finite: got %h ovf %b want %h ovf %b", o.res, o.ovf, e.res, e.ovf);
        end
        run_op(0, 1'b0, 32'h7F800000, 32'h3F800000, o);
        checks++;
        e = exp_q.pop_front();
        if (o.res !== e.res || o.ovf !== e.ovf || o.done_chan !== e.chan) begin
            errors++;
            $display("FAIL ovf_inf_operand: got %h ovf %b want %h ovf %b", o.res, o.ovf, e.res, e.ovf);
        end
        checks++;
        if (res1 !== 32'h40000000 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_res1_kept: got %h ovf %b want 40000000 ovf 0", res1, ovf1);
        end
    endtask

    task automatic test_back_to_back();
        int   ack_seq[$];
        int   ack_cyc[$];
        int   last_ack;
        int   dones;
        int   extra_acks;
        exp_t e;
        n_rst = 0;
        opa0 = 32'h3F800000; opb0 = 32'h40000000; sub0 = 0;
        opa1 = 32'h40400000; opb1 = 32'h3F800000; sub1 = 1;
        req0 = 1; req1 = 1;
        exp_q.push_back('{chan: 0, res: 32'h40400000, ovf: 1'b0});
        exp_q.push_back('{chan: 1, res: 32'h40000000, ovf: 1'b0});
        exp_q.push_back('{chan: 0, res: 32'h40400000, ovf: 1'b0});
        @(negedge clk);
        n_rst = 1;
        last_ack = -1;
        dones = 0;
        extra_acks = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack0 | ack1) begin
                if (ack_seq.size() < 3) begin
                    ack_seq.push_back(ack1 ? 1 : 0);
                    ack_cyc.push_back(n);
                end else begin
                    extra_acks++;
                end
                last_ack = ack1 ? 1 : 0;
                if (ack_seq.size() == 3) begin
                    req0 = 0; req1 = 0;
                end
            end
            if (done0 | done1) begin
                dones++;
                checks++;
                if ((done1 ? 1 : 0) !== last_ack) begin
                    errors++;
                    $display("FAIL b2b_done_chan: got %0d want %0d", done1 ? 1 : 0, last_ack);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_sb: got unexpected done want none");
                end else begin
                    e = exp_q.pop_front();
                    if ((done1 ? 1 : 0) !== e.chan || (done1 ? res1 : res0) !== e.res) begin
                        errors++;
                        $display("FAIL b2b_res: got chan %0d %h want chan %0d %h",
                                 done1 ? 1 : 0, done1 ? res1 : res0, e.chan, e.res);
                    end
                end
            end
        end
        req0 = 0; req1 = 0;
        checks++;
        if (ack_seq.size() != 3 || ack_seq[0] != 0 || ack_seq[1] != 1 || ack_seq[2] != 0) begin
            errors++;
            $display("FAIL b2b_order: got %p want '{0, 1, 0}", ack_seq);
        end
        checks++;
        if (ack_cyc.size() != 3 || ack_cyc[0] != 1 || ack_cyc[1] != 5 || ack_cyc[2] != 9) begin
            errors++;
            $display("FAIL b2b_spacing: got %p want '{1, 5, 9}", ack_cyc);
        end
        checks++;
        if (dones !== 3 || extra_acks !== 0) begin
            errors++;
            $display("FAIL b2b_count: got dones %0d extra acks %0d want 3 and 0", dones, extra_acks);
        end
    endtask

    task automatic test_reset_mid();
        int   pulses;
        exp_t e;
        req0 = 1; sub0 = 0; opa0 = 32'h3F800000; opb0 = 32'h40000000;
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ack0 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_in_wait: got busy %b ack0 %b want 1 0", busy, ack0);
        end
        n_rst = 0;
        #1;
        checks++;
        if ({ack0, ack1, done0, done1, ovf0, ovf1, add_serv, busy} !== 8'h00 ||
            {res0, res1, add_op1, add_op2} !== 128'h0) begin
            errors++;
            $display("FAIL rmid_clear: got %b %h want all 0",
                     {ack0, ack1, done0, done1, ovf0, ovf1, add_serv, busy},
                     {res0, res1, add_op1, add_op2});
        end
        @(negedge clk);
        n_rst = 1;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (ack0 | ack1 | done0 | done1 | busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rmid_quiet: got %0d active cycles want 0", pulses);
        end
        exp_q.push_back('{chan: 0, res: 32'h40400000, ovf: 1'b0});
        opa1 = 32'h40400000; opb1 = 32'h3F800000; sub1 = 1;
        req0 = 1; req1 = 1;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_tie: got ack0 %b ack1 %b want 1 0", ack0, ack1);
        end
        req0 = 0; req1 = 0;
        pulses = 0;
        for (int n = 0; n < 10 && pulses == 0; n++) begin
            @(negedge clk);
            if (done0 | done1) begin
                pulses++;
                e = exp_q.pop_front();
                checks++;
                if ((done1 ? 1 : 0) !== e.chan || res0 !== e.res || ovf0 !== e.ovf) begin
                    errors++;
                    $display("FAIL rmid_tie_res: got chan %0d %h want chan %0d %h",
                             done1 ? 1 : 0, res0, e.chan, e.res);
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL rmid_tie_done: got %0d done pulses want 1", pulses);
        end
        @(negedge clk);
    endtask

    task automatic test_lat4();
        int   ack_at;
        int   done_at;
        int   busy_cnt;
        exp_t e;
        ack_at = -1; done_at = -1; busy_cnt = 0;
        exp_q.push_back('{chan: 0, res: 32'h40400000, ovf: 1'b0});
        req0_b = 1; sub0_b = 0; opa0_b = 32'h3F800000; opb0_b = 32'h40000000;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (busy_b) busy_cnt++;
            if (ack0_b && ack_at < 0) begin
                ack_at = n;
                req0_b = 0;
            end
            if (done0_b && done_at < 0) begin
                done_at = n;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL lat4_sb: got unexpected done want none");
                end else begin
                    e = exp_q.pop_front();
                    if (res0_b !== e.res || ovf0_b !== e.ovf) begin
                        errors++;
                        $display("FAIL lat4_res: got %h ovf %b want %h ovf %b", res0_b, ovf0_b, e.res, e.ovf);
                    end
                end
            end
        end
        req0_b = 0;
        checks++;
        if (ack_at !== 1 || done_at - ack_at !== 5) begin
            errors++;
            $display("FAIL lat4_latency: got ack %0d done %0d want ack 1 done 6", ack_at, done_at);
        end
        checks++;
        if (busy_cnt !== 6) begin
            errors++;
            $display("FAIL lat4_busy: got %0d cycles want 6", busy_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_add0();
        test_sub1();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_lat4();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
Round-robin controller that shares one single-precision floating-point add/subtract datapath between two requesters. It accepts an operation from one requester at a time and optionally negates the second operand for subtract. It drives the datapath, waits a fixed settle latency, captures the result with an overflow flag, and returns it to the winning requester. It sits between the FPU command front-ends and the addsub datapath.

Parameters:
ADD_LAT, 1, datapath settle cycles between operand issue and result capture; legal range 1..15
WAIT_W, 4, width of the settle counter; must hold ADD_LAT

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
req0  in  1  requester 0 operation request; held with operands stable until ack0
sub0  in  1  requester 0 subtract select (1 = opa0 - opb0)
opa0  in  32  requester 0 operand A, IEEE-754 single
opb0  in  32  requester 0 operand B, IEEE-754 single
req1  in  1  requester 1 request
sub1  in  1  requester 1 subtract select
opa1  in  32  requester 1 operand A
opb1  in  32  requester 1 operand B
ack0  out  1  one-cycle pulse: requester 0 operands captured
ack1  out  1  one-cycle pulse: requester 1 operands captured
done0  out  1  one-cycle pulse: res0/ovf0 updated
done1  out  1  one-cycle pulse: res1/ovf1 updated
res0  out  32  last result for requester 0; held until its next done0
res1  out  32  last result for requester 1; held until its next done1
ovf0  out  1  overflow flag for res0; held like res0
ovf1  out  1  overflow flag for res1; held like res1
add_op1  out  32  datapath operand 1, registered
add_op2  out  32  datapath operand 2, registered, sign pre-flipped for subtract
add_serv  out  1  datapath service strobe, high during ISSUE only
add_result  in  32  datapath result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (n_rst low, asynchronous): state IDLE, all outputs 0, settle counter 0, round-robin pointer "last served" = 1, so requester 0 wins the first tie.
- Reset mid-operation aborts the operation. No ack or done is issued for it afterwards.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, no request: remain in IDLE.
- IDLE, any reqN high at a clock edge: pick the winner.
  - A single requester wins outright.
  - If both are high, the requester other than "last served" wins.
  - On that edge, capture add_op1 = opaN and add_op2 = {opbN[31]^subN, opbN[30:0]}.
  - Record the winner and update "last served" to the winner.
  - Go to ISSUE.
- ISSUE (1 cycle): ackN = 1 for the winner, add_serv = 1, busy = 1. Load the counter with ADD_LAT, then go to WAIT.
- WAIT: decrement the counter each cycle.
  - On the edge where the counter is 1, latch add_result into resN of the winner and compute ovfN.
  - Go to DONE.
  - The WAIT state lasts exactly ADD_LAT cycles.
- DONE (1 cycle): doneN = 1 for the winner, then go to IDLE.
- Latency:
  - Capture edge to ack = 1 cycle.
  - ack to done = ADD_LAT + 1 cycles.
  - Back-to-back operations start every ADD_LAT + 3 cycles.
- Requests are sampled only in IDLE. reqN still high during ISSUE, WAIT or DONE is ignored.
- A requester holding req after ack issues a new operation the next time the controller is in IDLE. Requesters must drop req in the cycle ack is seen.
- Overflow: ovfN = 1 when add_result[30:23] == 8'hFF and neither captured operand has exponent 8'hFF; otherwise 0.
- resN and ovfN of the non-winning requester are never modified.
- add_op1 and add_op2 hold their last values between operations; they are cleared only by reset.
- ack and done are mutually exclusive between channels and are never high in the same cycle.

Test Plan:
- Reset, then req0 only with opa0 = 3F800000 (1.0), opb0 = 40000000 (2.0), sub0 = 0. Required: ack0 at cycle +1, add_serv high the same cycle, done0 at cycle +3 (ADD_LAT = 1), res0 = 40400000 (3.0), ovf0 = 0.
- req1 only with sub1 = 1, opa1 = 40400000, opb1 = 3F800000. Required: add_op2 = BF800000, res1 = 40000000 (2.0), done1 only, res0/ovf0 unchanged.
- req0 and req1 both held high from reset. Required order: ack0, then ack1, then ack0 (strict alternation); each done matches the preceding ack's channel.
- opa0 = opb0 = 7F000000, sub0 = 0. Required: res0 = 7F800000, ovf0 = 1. Then opa0 = 7F800000, opb0 = 3F800000. Required: ovf0 = 0 (infinite operand).
- Assert n_rst low during WAIT. Required: all outputs 0 immediately. After release, no done pulse appears without a new request, and the next tie goes to requester 0.
- ADD_LAT = 4: a single req0. Required: done0 exactly 5 cycles after ack0, and busy high for exactly 6 cycles.
